top_of_book_tx: RTL and testbench
=================================

Name: top_of_book_tx

Overview:
- Transmit side of the per-stock quote stream consumed by the volatility engine.
- Takes single-sided quote updates (bid or ask, set or withdraw) per stock and keeps a best bid/ask table per stock.
- Emits a one-cycle snapshot {stock_id, best_ask, best_bid, data_valid} only when that stock's book is two-sided, uncrossed, and changed since its last emission.
- Sits between the feed decoder and the volatility block; its outputs connect directly to the volatility inputs i_stock_id, i_data_valid, i_best_ask and i_best_bid.

Parameters:
DATA_WIDTH, 32, price width in bits
NUM_STOCKS, 4, number of tracked stocks; table depth
CNT_WIDTH, 16, width of the crossed-book event counter

Ports:
i_clk  input  1  clock
i_reset  input  1  synchronous active-high reset
i_update_valid  input  1  quote update present this cycle
i_stock_id  input  $clog2(NUM_STOCKS)  stock the update applies to
i_side  input  1  0 = bid, 1 = ask
i_clear  input  1  1 = withdraw this side's quote
i_price  input  DATA_WIDTH  new price (unsigned) when i_clear = 0
o_stock_id  output  $clog2(NUM_STOCKS)  stock of the emitted snapshot
o_best_ask  output  DATA_WIDTH  emitted best ask
o_best_bid  output  DATA_WIDTH  emitted best bid
o_data_valid  output  1  snapshot valid strobe, one cycle
o_book_ready  output  NUM_STOCKS  bit s = stock s has both sides valid
o_crossed_count  output  CNT_WIDTH  saturating count of crossed/locked results

Behaviour:
- Single clock domain on i_clk.
- Reset is synchronous and active-high on i_reset.
- Reset takes effect at the edge where i_reset = 1, regardless of the pipeline state.
  - Clears every table entry: bid = 0, ask = 0, bid_valid = 0, ask_valid = 0.
  - Clears every last-emitted pair to {0,0}.
  - Drops any in-flight update.
  - Sets all outputs to 0.
- Pipeline, 2 stages, fully pipelined, accepts one update per cycle, never stalls, no backpressure.
  - S1: register the update fields; the update is taken when i_update_valid = 1.
  - S2: the table is read combinationally at the S1 stock_id and the modified entry is written.
  - S2: the emit decision is made and the output registers are loaded.
  - Latency: an update presented in cycle t gives o_data_valid in cycle t+2.
- Entry update in S2:
  - i_clear = 1: the selected side becomes valid = 0, price = 0.
  - i_clear = 0 and i_price = 0: treated as a clear of that side.
  - Otherwise: the selected side becomes price = i_price, valid = 1.
- Emit condition, evaluated on the post-update entry:
  - both sides valid, AND
  - bid < ask (unsigned), AND
  - {ask, bid} differs from that stock's last-emitted pair.
- On emit:
  - o_data_valid = 1 for exactly one cycle.
  - o_stock_id, o_best_ask and o_best_bid are loaded.
  - The last-emitted pair for that stock is updated.
- When not emitting: o_data_valid = 0 and o_stock_id, o_best_ask, o_best_bid hold their previous values.
- Crossed or locked result (both valid and bid >= ask):
  - The table is still updated.
  - No emit.
  - o_crossed_count increments and saturates at all-ones; it does not wrap.
- Withdraw of a side:
  - No emit.
  - The last-emitted pair is unchanged.
  - A later re-quote to the identical pair is therefore not re-emitted.
- o_book_ready is registered and reflects the table after the S2 write (same cycle as o_data_valid).
- Back-to-back updates to the same stock: the S2 read-then-write completes in one cycle, so update N+1 sees update N's result. No forwarding path is needed and no hazard exists.
- Updates to different stocks are independent. At most one emit per cycle.
- When NUM_STOCKS is not a power of two, an update with i_stock_id >= NUM_STOCKS is ignored entirely: no table write, no count.

Test Plan:
- Reset, then stock 1: bid 100 (cycle 0), ask 105 (cycle 1) -> no strobe from cycle 0; cycle 3: o_data_valid = 1, o_stock_id = 1, bid = 100, ask = 105; o_book_ready = 4'b0010.
- Stock 1 ask 105 repeated -> no strobe. Then ask 104 -> strobe with {104,100}. Then bid 104 -> no strobe, o_crossed_count = 1, o_book_ready[1] still 1.
- o_crossed_count forced to 0xFFFE, then three crossed updates -> count saturates at 0xFFFF.
- Stock 1 ask clear -> no strobe, o_book_ready[1] = 0. Then ask 104 with bid 100 -> no strobe (pair equals last emitted). Then ask 106 -> strobe {106,100}.
- Interleaved one-per-cycle updates across stocks 0, 2 and 3 that each complete a two-sided book -> one strobe per cycle, each exactly 2 cycles after its input, with correct per-stock values.
- i_reset asserted with an update in S1 -> no strobe; all outputs 0. A subsequent single-side update -> no strobe (table was cleared).

Source files
------------

// File: rtl/top_of_book_tx.sv
// Top-of-book transmitter: keeps a best bid/ask table per stock from
// single-sided quote updates and emits a one-cycle snapshot whenever a stock's
// book is two-sided, uncrossed and different from its last emitted pair.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_update_valid          quote update present this cycle
//   i_stock_id              stock the update applies to
//   i_side                  0 = bid, 1 = ask
//   i_clear                 1 = withdraw this side's quote
//   i_price                 new price (unsigned); 0 also withdraws the side
//   o_stock_id              stock of the emitted snapshot
//   o_best_ask, o_best_bid  emitted best ask / best bid
//   o_data_valid            one-cycle snapshot strobe
//   o_book_ready            bit s = stock s has both sides valid
//   o_crossed_count         saturating count of crossed/locked results
module top_of_book_tx #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_STOCKS = 4,
    parameter int unsigned CNT_WIDTH  = 16,
    localparam int unsigned ID_W      = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_update_valid,
    input  logic [ID_W-1:0]       i_stock_id,
    input  logic                  i_side,
    input  logic                  i_clear,
    input  logic [DATA_WIDTH-1:0] i_price,
    output logic [ID_W-1:0]       o_stock_id,
    output logic [DATA_WIDTH-1:0] o_best_ask,
    output logic [DATA_WIDTH-1:0] o_best_bid,
    output logic                  o_data_valid,
    output logic [NUM_STOCKS-1:0] o_book_ready,
    output logic [CNT_WIDTH-1:0]  o_crossed_count
);

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic                  r_s1_valid;
    logic [ID_W-1:0]       r_s1_id;
    logic                  r_s1_side;
    logic                  r_s1_clear;
    logic [DATA_WIDTH-1:0] r_s1_price;

    // ------------------------------------------------------------------
    // Per-stock book table and last-emitted pairs
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_bid      [NUM_STOCKS];
    logic [DATA_WIDTH-1:0] r_ask      [NUM_STOCKS];
    logic [DATA_WIDTH-1:0] r_last_bid [NUM_STOCKS];
    logic [DATA_WIDTH-1:0] r_last_ask [NUM_STOCKS];
    logic [NUM_STOCKS-1:0] r_bid_v;
    logic [NUM_STOCKS-1:0] r_ask_v;

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [ID_W-1:0]       r_out_id;
    logic [DATA_WIDTH-1:0] r_out_ask;
    logic [DATA_WIDTH-1:0] r_out_bid;
    logic                  r_data_valid;
    logic [NUM_STOCKS-1:0] r_book_ready;
    logic [CNT_WIDTH-1:0]  r_crossed_cnt;

    // ------------------------------------------------------------------
    // Stage 2 combinational signals
    // ------------------------------------------------------------------
    logic                  w_id_in_range;
    logic [DATA_WIDTH-1:0] w_cur_bid;
    logic [DATA_WIDTH-1:0] w_cur_ask;
    logic                  w_cur_bid_v;
    logic                  w_cur_ask_v;
    logic [DATA_WIDTH-1:0] w_cur_last_bid;
    logic [DATA_WIDTH-1:0] w_cur_last_ask;
    logic [DATA_WIDTH-1:0] w_new_bid;
    logic [DATA_WIDTH-1:0] w_new_ask;
    logic                  w_new_bid_v;
    logic                  w_new_ask_v;
    logic                  w_both;
    logic                  w_crossed;
    logic                  w_changed;
    logic                  w_emit;
    logic [NUM_STOCKS-1:0] w_ready_next;

    // Out-of-range ids only exist when NUM_STOCKS is not a power of two.
    generate
        if (NUM_STOCKS == (1 << ID_W)) begin : g_id_full
            assign w_id_in_range = 1'b1;
        end else begin : g_id_check
            assign w_id_in_range = (32'(i_stock_id) < NUM_STOCKS);
        end
    endgenerate

    // Read the entry addressed by the stage-1 stock id.
    always_comb begin
        w_cur_bid      = '0;
        w_cur_ask      = '0;
        w_cur_bid_v    = 1'b0;
        w_cur_ask_v    = 1'b0;
        w_cur_last_bid = '0;
        w_cur_last_ask = '0;
        for (int unsigned s = 0; s < NUM_STOCKS; s++) begin
            if (r_s1_id == ID_W'(s)) begin
                w_cur_bid      = r_bid[s];
                w_cur_ask      = r_ask[s];
                w_cur_bid_v    = r_bid_v[s];
                w_cur_ask_v    = r_ask_v[s];
                w_cur_last_bid = r_last_bid[s];
                w_cur_last_ask = r_last_ask[s];
            end
        end
    end

    // Apply the update to the selected side; a clear zeroes price and valid.
    always_comb begin
        w_new_bid   = w_cur_bid;
        w_new_ask   = w_cur_ask;
        w_new_bid_v = w_cur_bid_v;
        w_new_ask_v = w_cur_ask_v;
        if (r_s1_side == 1'b0) begin
            w_new_bid   = r_s1_clear ? '0 : r_s1_price;
            w_new_bid_v = ~r_s1_clear;
        end else begin
            w_new_ask   = r_s1_clear ? '0 : r_s1_price;
            w_new_ask_v = ~r_s1_clear;
        end
    end

    // Emit / crossed decision on the post-update entry.
    always_comb begin
        w_both    = w_new_bid_v & w_new_ask_v;
        w_crossed = r_s1_valid & w_both & (w_new_bid >= w_new_ask);
        w_changed = (w_new_ask != w_cur_last_ask) | (w_new_bid != w_cur_last_bid);
        w_emit    = r_s1_valid & w_both & (w_new_bid < w_new_ask) & w_changed;
    end

    // Book-ready view of the table as it will be after this cycle's write.
    always_comb begin
        w_ready_next = r_bid_v & r_ask_v;
        for (int unsigned s = 0; s < NUM_STOCKS; s++) begin
            if (r_s1_valid && (r_s1_id == ID_W'(s))) begin
                w_ready_next[s] = w_both;
            end
        end
    end

    // Pipeline, table and output state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_valid    <= 1'b0;
            r_s1_id       <= '0;
            r_s1_side     <= 1'b0;
            r_s1_clear    <= 1'b0;
            r_s1_price    <= '0;
            r_bid_v       <= '0;
            r_ask_v       <= '0;
            for (int unsigned s = 0; s < NUM_STOCKS; s++) begin
                r_bid[s]      <= '0;
                r_ask[s]      <= '0;
                r_last_bid[s] <= '0;
                r_last_ask[s] <= '0;
            end
            r_out_id      <= '0;
            r_out_ask     <= '0;
            r_out_bid     <= '0;
            r_data_valid  <= 1'b0;
            r_book_ready  <= '0;
            r_crossed_cnt <= '0;
        end else begin
            // Stage 1: capture the update; a zero price is folded into a clear.
            r_s1_valid <= i_update_valid & w_id_in_range;
            r_s1_id    <= i_stock_id;
            r_s1_side  <= i_side;
            r_s1_clear <= i_clear | (i_price == '0);
            r_s1_price <= i_price;

            // Stage 2: write back the modified entry.
            if (r_s1_valid) begin
                for (int unsigned s = 0; s < NUM_STOCKS; s++) begin
                    if (r_s1_id == ID_W'(s)) begin
                        r_bid[s]   <= w_new_bid;
                        r_ask[s]   <= w_new_ask;
                        r_bid_v[s] <= w_new_bid_v;
                        r_ask_v[s] <= w_new_ask_v;
                        if (w_emit) begin
                            r_last_bid[s] <= w_new_bid;
                            r_last_ask[s] <= w_new_ask;
                        end
                    end
                end
            end

            // Snapshot outputs hold their value when nothing is emitted.
            r_data_valid <= w_emit;
            if (w_emit) begin
                r_out_id  <= r_s1_id;
                r_out_ask <= w_new_ask;
                r_out_bid <= w_new_bid;
            end

            r_book_ready <= w_ready_next;

            if (w_crossed && (r_crossed_cnt != '1)) begin
                r_crossed_cnt <= r_crossed_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign o_stock_id      = r_out_id;
    assign o_best_ask      = r_out_ask;
    assign o_best_bid      = r_out_bid;
    assign o_data_valid    = r_data_valid;
    assign o_book_ready    = r_book_ready;
    assign o_crossed_count = r_crossed_cnt;

endmodule

// File: tb/tb_top_of_book_tx.sv
// Directed testbench for top_of_book_tx. A default instance (4 stocks, 16-bit
// counter) covers emit/no-emit, crossed, withdraw, pipelining and reset; a
// second instance (3 stocks, 2-bit counter) covers counter saturation and
// rejection of out-of-range stock ids.
module tb_top_of_book_tx;

    localparam int unsigned DW = 32;

    logic clk;
    logic rst;

    // Main instance signals
    logic          m_valid;
    logic [1:0]    m_id;
    logic          m_side;
    logic          m_clear;
    logic [DW-1:0] m_price;
    logic [1:0]    m_o_id;
    logic [DW-1:0] m_o_ask;
    logic [DW-1:0] m_o_bid;
    logic          m_o_dv;
    logic [3:0]    m_o_ready;
    logic [15:0]   m_o_cnt;

    // Saturation / out-of-range instance signals
    logic          s_valid;
    logic [1:0]    s_id;
    logic          s_side;
    logic          s_clear;
    logic [DW-1:0] s_price;
    logic [1:0]    s_o_id;
    logic [DW-1:0] s_o_ask;
    logic [DW-1:0] s_o_bid;
    logic          s_o_dv;
    logic [2:0]    s_o_ready;
    logic [1:0]    s_o_cnt;

    int n_cmp;
    int n_bad;

    top_of_book_tx u_dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_update_valid  (m_valid),
        .i_stock_id      (m_id),
        .i_side          (m_side),
        .i_clear         (m_clear),
        .i_price         (m_price),
        .o_stock_id      (m_o_id),
        .o_best_ask      (m_o_ask),
        .o_best_bid      (m_o_bid),
        .o_data_valid    (m_o_dv),
        .o_book_ready    (m_o_ready),
        .o_crossed_count (m_o_cnt)
    );

    top_of_book_tx #(
        .DATA_WIDTH (DW),
        .NUM_STOCKS (3),
        .CNT_WIDTH  (2)
    ) u_sat (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_update_valid  (s_valid),
        .i_stock_id      (s_id),
        .i_side          (s_side),
        .i_clear         (s_clear),
        .i_price         (s_price),
        .o_stock_id      (s_o_id),
        .o_best_ask      (s_o_ask),
        .o_best_bid      (s_o_bid),
        .o_data_valid    (s_o_dv),
        .o_book_ready    (s_o_ready),
        .o_crossed_count (s_o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One update on the selected instance for one cycle; valid drops afterwards.
    task automatic upd(input bit sat, input int id, input bit side, input bit clr,
                       input logic [DW-1:0] price);
        if (sat) begin
            s_valid = 1'b1; s_id = 2'(id); s_side = side; s_clear = clr; s_price = price;
        end else begin
            m_valid = 1'b1; m_id = 2'(id); m_side = side; m_clear = clr; m_price = price;
        end
        tick();
        m_valid = 1'b0;
        s_valid = 1'b0;
    endtask

    localparam bit BID = 1'b0;
    localparam bit ASK = 1'b1;

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        m_valid = 1'b0; m_id = '0; m_side = 1'b0; m_clear = 1'b0; m_price = '0;
        s_valid = 1'b0; s_id = '0; s_side = 1'b0; s_clear = 1'b0; s_price = '0;
        repeat (2) tick();

        check("rst_dv",    64'(m_o_dv),    64'd0);
        check("rst_ready", 64'(m_o_ready), 64'd0);
        check("rst_cnt",   64'(m_o_cnt),   64'd0);
        check("rst_ask",   64'(m_o_ask),   64'd0);
        rst = 1'b0;

        // Two-sided book on stock 1: bid then ask, strobe two cycles after the ask.
        upd(0, 1, BID, 0, 100);
        upd(0, 1, ASK, 0, 105);
        check("bid_only_dv", 64'(m_o_dv), 64'd0);
        tick();
        check("first_dv",    64'(m_o_dv),    64'd1);
        check("first_id",    64'(m_o_id),    64'd1);
        check("first_ask",   64'(m_o_ask),   64'd105);
        check("first_bid",   64'(m_o_bid),   64'd100);
        check("first_ready", 64'(m_o_ready), 64'b0010);
        tick();
        check("strobe_one_cycle", 64'(m_o_dv), 64'd0);

        // Unchanged pair is suppressed; a new ask emits.
        upd(0, 1, ASK, 0, 105); tick();
        check("repeat_dv", 64'(m_o_dv), 64'd0);
        upd(0, 1, ASK, 0, 104); tick();
        check("ask104_dv",  64'(m_o_dv),  64'd1);
        check("ask104_ask", 64'(m_o_ask), 64'd104);
        check("ask104_bid", 64'(m_o_bid), 64'd100);

        // Locked book: no emit, counter bumps, book stays ready, outputs hold.
        upd(0, 1, BID, 0, 104); tick();
        check("locked_dv",    64'(m_o_dv),    64'd0);
        check("locked_cnt",   64'(m_o_cnt),   64'd1);
        check("locked_ready", 64'(m_o_ready), 64'b0010);
        check("locked_hold",  64'(m_o_bid),   64'd100);

        // Withdraw ask, re-quote to the last emitted pair, then a new ask.
        upd(0, 1, ASK, 1, 999); tick();
        check("clr_dv",    64'(m_o_dv),    64'd0);
        check("clr_ready", 64'(m_o_ready), 64'b0000);
        upd(0, 1, BID, 0, 100); tick();
        upd(0, 1, ASK, 0, 104); tick();
        check("requote_dv",    64'(m_o_dv),    64'd0);
        check("requote_ready", 64'(m_o_ready), 64'b0010);
        check("requote_cnt",   64'(m_o_cnt),   64'd1);
        upd(0, 1, ASK, 0, 106); tick();
        check("ask106_dv",  64'(m_o_dv),  64'd1);
        check("ask106_ask", 64'(m_o_ask), 64'd106);
        check("ask106_bid", 64'(m_o_bid), 64'd100);

        // Zero price without i_clear acts as a withdraw; restoring bid re-forms the same pair.
        upd(0, 1, BID, 0, 0); tick();
        check("zero_dv",    64'(m_o_dv),    64'd0);
        check("zero_ready", 64'(m_o_ready), 64'b0000);
        upd(0, 1, BID, 0, 100); tick();
        check("zero_requote_dv", 64'(m_o_dv), 64'd0);

        // Interleaved one-per-cycle updates across stocks 0, 2, 3.
        upd(0, 0, BID, 0, 10);
        upd(0, 2, BID, 0, 20);
        check("il_b0_dv", 64'(m_o_dv), 64'd0);
        upd(0, 3, BID, 0, 30);
        upd(0, 0, ASK, 0, 11);
        upd(0, 2, ASK, 0, 25);
        check("il_s0_dv",  64'(m_o_dv),  64'd1);
        check("il_s0_id",  64'(m_o_id),  64'd0);
        check("il_s0_val", {m_o_ask, m_o_bid}, {32'd11, 32'd10});
        upd(0, 3, ASK, 0, 35);
        check("il_s2_dv",  64'(m_o_dv),  64'd1);
        check("il_s2_id",  64'(m_o_id),  64'd2);
        check("il_s2_val", {m_o_ask, m_o_bid}, {32'd25, 32'd20});
        tick();
        check("il_s3_dv",    64'(m_o_dv),    64'd1);
        check("il_s3_id",    64'(m_o_id),    64'd3);
        check("il_s3_val",   {m_o_ask, m_o_bid}, {32'd35, 32'd30});
        check("il_ready",    64'(m_o_ready), 64'b1111);
        tick();
        check("il_idle_dv",  64'(m_o_dv),    64'd0);

        // Back-to-back updates to the same stock see each other's result.
        upd(0, 0, ASK, 0, 12);
        upd(0, 0, ASK, 0, 13);
        check("b2b_first",  {m_o_ask, m_o_bid}, {32'd12, 32'd10});
        check("b2b_dv1",    64'(m_o_dv), 64'd1);
        tick();
        check("b2b_second", {m_o_ask, m_o_bid}, {32'd13, 32'd10});
        check("b2b_dv2",    64'(m_o_dv), 64'd1);

        // Saturating counter and out-of-range ids on the 3-stock, 2-bit instance.
        upd(1, 0, BID, 0, 50); tick();
        check("sat_c0", 64'(s_o_cnt), 64'd0);
        upd(1, 0, ASK, 0, 40); tick();
        check("sat_c1", 64'(s_o_cnt), 64'd1);
        upd(1, 0, ASK, 0, 45); tick();
        check("sat_c2", 64'(s_o_cnt), 64'd2);
        upd(1, 0, ASK, 0, 30); tick();
        check("sat_c3", 64'(s_o_cnt), 64'd3);
        upd(1, 0, ASK, 0, 20); tick();
        check("sat_hold", 64'(s_o_cnt), 64'd3);
        check("sat_dv",   64'(s_o_dv),  64'd0);
        upd(1, 3, BID, 0, 5);
        upd(1, 3, ASK, 0, 9); tick();
        check("oor_dv",    64'(s_o_dv),    64'd0);
        check("oor_ready", 64'(s_o_ready), 64'b001);
        upd(1, 2, BID, 0, 5);
        upd(1, 2, ASK, 0, 9); tick();
        check("s2_dv",  64'(s_o_dv), 64'd1);
        check("s2_id",  64'(s_o_id), 64'd2);
        check("s2_val", {s_o_ask, s_o_bid}, {32'd9, 32'd5});

        // Reset while an update sits in stage 1.
        upd(0, 2, BID, 0, 50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_dv",    64'(m_o_dv),    64'd0);
        check("mid_rst_ready", 64'(m_o_ready), 64'd0);
        check("mid_rst_cnt",   64'(m_o_cnt),   64'd0);
        check("mid_rst_out",   {30'd0, m_o_id, m_o_ask}, 64'd0);
        check("mid_rst_bid",   64'(m_o_bid),   64'd0);
        tick();
        check("mid_rst_drop",  64'(m_o_dv),    64'd0);
        upd(0, 2, ASK, 0, 60); tick();
        check("post_rst_dv",    64'(m_o_dv),    64'd0);
        check("post_rst_ready", 64'(m_o_ready), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
